// File: rtl/button_press_classifier.sv
// Push-button front end: 2-flop synchroniser, debouncer and short/long/auto-repeat
// press classifier producing registered one-cycle pulses.
module button_press_classifier #(
  parameter int ACTIVE_HIGH     = 1,
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int LONG_CYCLES     = 10000,
  parameter int REPEAT_CYCLES   = 2000,
  parameter int CNT_W           = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic btn_raw,
  output logic btn_level,
  output logic inc_short,
  output logic inc_long,
  output logic inc_repeat
);

  localparam logic             RAW_RELEASED = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST    = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST     = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  logic             sync1_r;
  logic             sync2_r;
  logic             btn_sync_s;
  logic             btn_level_d_r;
  logic             rise_s;
  logic             fall_s;
  logic [CNT_W-1:0] db_cnt_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [CNT_W-1:0] hold_cnt_nxt_s;
  logic [CNT_W-1:0] rep_cnt_r;
  logic [CNT_W-1:0] rep_cnt_nxt_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic             short_nxt_s;
  logic             long_nxt_s;
  logic             repeat_nxt_s;

  // Two-flop synchroniser on the raw pin; resets to the released level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= RAW_RELEASED;
      sync2_r <= RAW_RELEASED;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  assign btn_sync_s = (ACTIVE_HIGH != 0) ? sync2_r : ~sync2_r;

  // Debouncer: accept a level change only after it has persisted long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_r      <= CNT_ZERO;
      btn_level     <= 1'b0;
      btn_level_d_r <= 1'b0;
    end else begin
      btn_level_d_r <= btn_level;
      if (btn_sync_s == btn_level) begin
        db_cnt_r <= CNT_ZERO;
      end else if (db_cnt_r == DB_LAST) begin
        btn_level <= ~btn_level;
        db_cnt_r  <= CNT_ZERO;
      end else begin
        db_cnt_r <= db_cnt_r + CNT_ONE;
      end
    end
  end

  assign rise_s = btn_level & ~btn_level_d_r;
  assign fall_s = ~btn_level & btn_level_d_r;

  // Classifier next-state and pulse decode; a release always beats a threshold tick.
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    rep_cnt_nxt_s  = rep_cnt_r;
    short_nxt_s    = 1'b0;
    long_nxt_s     = 1'b0;
    repeat_nxt_s   = 1'b0;
    if (!enable) begin
      state_nxt_s    = IDLE;
      hold_cnt_nxt_s = CNT_ZERO;
      rep_cnt_nxt_s  = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          hold_cnt_nxt_s = CNT_ZERO;
          rep_cnt_nxt_s  = CNT_ZERO;
          if (rise_s) begin
            state_nxt_s = PRESS;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        PRESS: begin
          if (fall_s) begin
            short_nxt_s    = 1'b1;
            state_nxt_s    = IDLE;
            hold_cnt_nxt_s = CNT_ZERO;
          end else if (hold_cnt_r == LONG_LAST) begin
            long_nxt_s     = 1'b1;
            state_nxt_s    = LONG;
            hold_cnt_nxt_s = CNT_ZERO;
            rep_cnt_nxt_s  = CNT_ZERO;
          end else begin
            hold_cnt_nxt_s = hold_cnt_r + CNT_ONE;
          end
        end
        LONG: begin
          if (fall_s) begin
            state_nxt_s   = IDLE;
            rep_cnt_nxt_s = CNT_ZERO;
          end else if (rep_cnt_r == REP_LAST) begin
            repeat_nxt_s  = 1'b1;
            rep_cnt_nxt_s = CNT_ZERO;
          end else begin
            rep_cnt_nxt_s = rep_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s    = IDLE;
          hold_cnt_nxt_s = CNT_ZERO;
          rep_cnt_nxt_s  = CNT_ZERO;
        end
      endcase
    end
  end

  // Classifier state, counters and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      hold_cnt_r <= CNT_ZERO;
      rep_cnt_r  <= CNT_ZERO;
      inc_short  <= 1'b0;
      inc_long   <= 1'b0;
      inc_repeat <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      rep_cnt_r  <= rep_cnt_nxt_s;
      inc_short  <= short_nxt_s;
      inc_long   <= long_nxt_s;
      inc_repeat <= repeat_nxt_s;
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: directed press scenarios plus random traffic,
// checked every cycle against a timing-rule reference model.
module tb_button_press_classifier;

  localparam int ACTIVE_HIGH = 1;
  localparam int DB = 4;
  localparam int LC = 20;
  localparam int RC = 5;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic btn_raw;
  logic btn_level;
  logic inc_short;
  logic inc_long;
  logic inc_repeat;

  always #5 clk = ~clk;

  button_press_classifier #(
    .ACTIVE_HIGH    (ACTIVE_HIGH),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC),
    .REPEAT_CYCLES  (RC),
    .CNT_W          (14)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .inc_short (inc_short),
    .inc_long  (inc_long),
    .inc_repeat(inc_repeat)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: debounced level history plus the edge index a press began.
  int m_cycle = 0;
  bit m_level = 1'b0;
  bit m_level_d = 1'b0;
  int m_run = 0;
  bit m_dly[2];
  bit m_active = 1'b0;
  int m_start = 0;
  bit e_short, e_long, e_rep;

  // Per-scenario observations.
  int n_short, n_long, n_rep, scn_step, first_hi;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs that edge samples.
  task automatic model_edge(input logic r, input logic en, input logic raw);
    bit lvl_b  = m_level;
    bit rise_b = m_level && !m_level_d;
    bit fall_b = !m_level && m_level_d;
    bit sync_b = m_dly[1];
    int age;
    m_cycle++;
    e_short = 1'b0;
    e_long  = 1'b0;
    e_rep   = 1'b0;
    if (r) begin
      m_level   = 1'b0;
      m_level_d = 1'b0;
      m_run     = 0;
      m_dly[0]  = 1'b0;
      m_dly[1]  = 1'b0;
      m_active  = 1'b0;
    end else begin
      if (!en) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (rise_b) begin
          m_active = 1'b1;
          m_start  = m_cycle;
        end
      end else begin
        age = m_cycle - m_start;
        if (fall_b) begin
          e_short  = (age <= LC);
          m_active = 1'b0;
        end else if (age == LC) begin
          e_long = 1'b1;
        end else if (age > LC && ((age - LC) % RC) == 0) begin
          e_rep = 1'b1;
        end
      end
      // level flips once the synchronised input has disagreed for DB samples in a row
      if (sync_b != m_level) begin
        m_run++;
        if (m_run == DB) begin
          m_level = !m_level;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_level_d = lvl_b;
      m_dly[1]  = m_dly[0];
      m_dly[0]  = (ACTIVE_HIGH != 0) ? raw : !raw;
    end
  endtask

  task automatic step(input logic r, input logic en, input logic raw);
    reset   = r;
    enable  = en;
    btn_raw = raw;
    @(posedge clk);
    model_edge(r, en, raw);
    #1;
    check_val("btn_level", int'(btn_level), int'(m_level));
    check_val("inc_short", int'(inc_short), int'(e_short));
    check_val("inc_long", int'(inc_long), int'(e_long));
    check_val("inc_repeat", int'(inc_repeat), int'(e_rep));
    n_short += int'(inc_short);
    n_long  += int'(inc_long);
    n_rep   += int'(inc_repeat);
    scn_step++;
    if (btn_level && first_hi < 0) first_hi = scn_step;
  endtask

  task automatic run(input int n, input logic en, input logic raw);
    for (int i = 0; i < n; i++) step(1'b0, en, raw);
  endtask

  task automatic start_scn();
    n_short  = 0;
    n_long   = 0;
    n_rep    = 0;
    scn_step = 0;
    first_hi = -1;
  endtask

  task automatic expect_counts(input string tag, input int s, input int l, input int rp);
    check_val({tag, "_short"}, n_short, s);
    check_val({tag, "_long"}, n_long, l);
    check_val({tag, "_repeat"}, n_rep, rp);
  endtask

  initial begin
    int len;
    logic r_raw, r_en;
    m_dly[0] = 1'b0;
    m_dly[1] = 1'b0;
    start_scn();

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    check_val("reset_outs", int'({btn_level, inc_short, inc_long, inc_repeat}), 0);
    run(5, 1'b1, 1'b0);

    // Bounce rejection.
    start_scn();
    run(3, 1'b1, 1'b1);
    run(10, 1'b1, 1'b0);
    check_val("glitch_level", first_hi, -1);
    expect_counts("glitch", 0, 0, 0);

    // Short press.
    start_scn();
    run(15, 1'b1, 1'b1);
    run(12, 1'b1, 1'b0);
    check_val("short_rise_lat", first_hi, DB + 2);
    expect_counts("short", 1, 0, 0);

    // Long hold; final repeat tick coincides with the release and is suppressed.
    start_scn();
    run(60, 1'b1, 1'b1);
    run(12, 1'b1, 1'b0);
    expect_counts("long", 0, 1, 7);

    // Release lands on the last hold cycle: short wins.
    start_scn();
    run(20, 1'b1, 1'b1);
    run(12, 1'b1, 1'b0);
    expect_counts("tie", 1, 0, 0);

    // One cycle longer than the tie crosses the threshold.
    start_scn();
    run(21, 1'b1, 1'b1);
    run(12, 1'b1, 1'b0);
    expect_counts("tie_plus1", 0, 1, 0);

    // Enable gating mid-press, re-enabled while still held.
    start_scn();
    run(10, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);
    run(20, 1'b1, 1'b1);
    run(12, 1'b1, 1'b0);
    expect_counts("gated", 0, 0, 0);
    start_scn();
    run(10, 1'b1, 1'b1);
    run(12, 1'b1, 1'b0);
    expect_counts("regated", 1, 0, 0);

    // Reset mid-hold with the button still down.
    start_scn();
    run(17, 1'b1, 1'b1);
    expect_counts("pre_reset", 0, 0, 0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check_val("reset_hold_outs", int'({btn_level, inc_short, inc_long, inc_repeat}), 0);
    start_scn();
    run(40, 1'b1, 1'b1);
    run(12, 1'b1, 1'b0);
    check_val("reset_rise_lat", first_hi, DB + 2);
    expect_counts("post_reset", 0, 1, 3);

    // Random traffic against the model.
    for (int blk = 0; blk < 60; blk++) begin
      len   = $urandom_range(1, 35);
      r_raw = 1'($urandom_range(0, 1));
      r_en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) begin
        step(1'b1, r_en, r_raw);
        step(1'b1, r_en, r_raw);
      end else begin
        run(len, r_en, r_raw);
      end
    end
    run(15, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
